// File: rtl/turbo_pkg.sv
// Shared definitions for the duobinary turbo encoder.
// Contents: block lengths per pb_size code, pb_size encodings, symbol counter
// width, block FSM state type and the pb_size -> length decode helper.
// Optional feature macro used by the top: TURBO_PUNCT_EN (rate 2/3 parity mask).
package turbo_pkg;

  localparam int CNT_W = 12;

  localparam logic [CNT_W-1:0] LEN_PB16  = 12'd64;
  localparam logic [CNT_W-1:0] LEN_PB136 = 12'd544;
  localparam logic [CNT_W-1:0] LEN_PB520 = 12'd2080;

  localparam logic [1:0] PB16  = 2'b00;
  localparam logic [1:0] PB136 = 2'b01;
  localparam logic [1:0] PB520 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } blk_state_e;

  // The reserved code 2'b11 falls through to the largest block.
  function automatic logic [CNT_W-1:0] pb_len(input logic [1:0] pb);
    case (pb)
      PB16:    pb_len = LEN_PB16;
      PB136:   pb_len = LEN_PB136;
      default: pb_len = LEN_PB520;
    endcase
  endfunction

endpackage

// File: rtl/rsc_duo_enc.sv
// One 8-state recursive systematic duobinary constituent encoder.
// Ports:
//   clk    in   system clock, rising edge
//   n_rst  in   asynchronous active-low reset (state -> 3'b000)
//   en     in   advance the trellis by one symbol this cycle
//   clr    in   with en: return to the zero state instead of advancing
//   u[1:0] in   input symbol {u1,u2}
//   p      out  parity bit for u from the current state (combinational)
// Optional feature macros: none.
module rsc_duo_enc
  import turbo_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] u,
  output logic       p
);

  // state_q = {s1, s2, s3}
  logic [2:0] state_q;
  logic       w;
  logic [2:0] state_nxt;

  always_comb begin
    w         = state_q[0] ^ u[1] ^ u[0];
    p         = w ^ state_q[1] ^ state_q[0];
    state_nxt = {w, state_q[2] ^ u[0], state_q[1] ^ u[0]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= 3'b000;
    end else if (en) begin
      // Each block starts from the zero state; no trellis termination.
      state_q <= clr ? 3'b000 : state_nxt;
    end
  end

endmodule

// File: rtl/turbo_duo_enc.sv
// Duobinary turbo encoder core: two constituent encoders (natural and
// interleaved order), block symbol counter / FSM, registered outputs and
// per-symbol parity keep mask.
// Ports:
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   pb_size[1:0]  in   block size select, sampled on symbol 0 of a block
//   din_sys[1:0]  in   natural-order symbol {u1,u2}
//   din_itl[1:0]  in   interleaved-order symbol {u1,u2}
//   din_vld       in   both input symbols valid
//   dout_sys[1:0] out  systematic symbol, 1 cycle after input
//   dout_par[1:0] out  {p2,p1}: p1 natural encoder, p2 interleaved encoder
//   par_mask[1:0] out  {keep p2, keep p1}; 2'b00 when dout_vld is low
//   dout_vld      out  outputs valid
//   blk_last      out  last symbol of a block, qualified by dout_vld
// Handshake: din_vld is a pure valid strobe, no ready/backpressure; one symbol
// per cycle, output valid exactly one cycle later.
// Optional feature macro: TURBO_PUNCT_EN -- when defined the mask punctures to
// rate 2/3 (01 on even symbol index, 10 on odd); otherwise rate 1/2 (11).
module turbo_duo_enc
  import turbo_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] pb_size,
  input  logic [1:0] din_sys,
  input  logic [1:0] din_itl,
  input  logic       din_vld,
  output logic [1:0] dout_sys,
  output logic [1:0] dout_par,
  output logic [1:0] par_mask,
  output logic       dout_vld,
  output logic       blk_last
);

  blk_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_cur;
  logic             last;
  logic             p1;
  logic             p2;
  logic [1:0]       mask_nxt;

  // In IDLE the block length comes straight from pb_size so symbol 0 is
  // judged against the length it is latching; afterwards pb_size is ignored.
  always_comb begin
    len_cur = (state_q == ST_IDLE) ? pb_len(pb_size) : len_q;
    last    = din_vld && (cnt_q == len_cur - CNT_W'(1));
  end

  always_comb begin
`ifdef TURBO_PUNCT_EN
    mask_nxt = cnt_q[0] ? 2'b10 : 2'b01;
`else
    mask_nxt = 2'b11;
`endif
  end

  rsc_duo_enc u_enc_nat (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (din_vld),
    .clr   (last),
    .u     (din_sys),
    .p     (p1)
  );

  rsc_duo_enc u_enc_itl (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (din_vld),
    .clr   (last),
    .u     (din_itl),
    .p     (p2)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= LEN_PB16;
      dout_sys <= 2'b00;
      dout_par <= 2'b00;
      par_mask <= 2'b00;
      dout_vld <= 1'b0;
      blk_last <= 1'b0;
    end else begin
      dout_vld <= din_vld;
      blk_last <= last;
      par_mask <= din_vld ? mask_nxt : 2'b00;
      if (din_vld) begin
        dout_sys <= din_sys;
        dout_par <= {p2, p1};
        if (state_q == ST_IDLE) begin
          len_q <= len_cur;
        end
        if (last) begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end else begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_turbo_duo_enc.sv
// Self-checking bench for turbo_duo_enc: directed steps with randomized data,
// checked against a behavioural model of the encoder and block framing.
// Honors TURBO_PUNCT_EN the same way the design does.
module tb_turbo_duo_enc;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] pb_size;
  logic [1:0] din_sys;
  logic [1:0] din_itl;
  logic       din_vld;
  logic [1:0] dout_sys;
  logic [1:0] dout_par;
  logic [1:0] par_mask;
  logic       dout_vld;
  logic       blk_last;

  turbo_duo_enc dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .pb_size  (pb_size),
    .din_sys  (din_sys),
    .din_itl  (din_itl),
    .din_vld  (din_vld),
    .dout_sys (dout_sys),
    .dout_par (dout_par),
    .par_mask (par_mask),
    .dout_vld (dout_vld),
    .blk_last (blk_last)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // scoreboard: {sys[1:0], par[1:0], mask[1:0], last}
  logic [6:0] exp_q[$];

  // reference model state
  int         m_st1, m_st2, m_idx, m_len;
  logic [1:0] hold_sys, hold_par;
  int         vld_seen, last_seen;

  function automatic int len_of(input logic [1:0] pb);
    if (pb == 2'b00) return 64;
    if (pb == 2'b01) return 544;
    return 2080;
  endfunction

  // One trellis step of the constituent encoder, straight from its equations.
  task automatic enc(input int st, input logic [1:0] u, output int nst, output logic p);
    logic [2:0] s;
    logic       w;
    s   = st[2:0];
    w   = s[0] ^ u[1] ^ u[0];
    p   = w ^ s[1] ^ s[0];
    nst = int'({w, s[2] ^ u[0], s[1] ^ u[0]});
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st1 = 0; m_st2 = 0; m_idx = 0; m_len = 64;
    hold_sys = 2'b00; hold_par = 2'b00;
    exp_q.delete();
  endtask

  // Drive one cycle of input, then check the registered outputs.
  task automatic step(input logic v, input logic [1:0] s, input logic [1:0] i,
                      input logic [1:0] pb);
    logic       p1, p2, last;
    logic [1:0] mask;
    int         n1, n2;
    logic [6:0] e;
    din_vld = v; din_sys = s; din_itl = i; pb_size = pb;
    if (v) begin
      if (m_idx == 0) m_len = len_of(pb);
      enc(m_st1, s, n1, p1);
      enc(m_st2, i, n2, p2);
      last = (m_idx == m_len - 1);
`ifdef TURBO_PUNCT_EN
      mask = (m_idx % 2 == 0) ? 2'b01 : 2'b10;
`else
      mask = 2'b11;
`endif
      exp_q.push_back({s, p2, p1, mask, last});
      if (last) begin
        m_idx = 0; m_st1 = 0; m_st2 = 0;
      end else begin
        m_idx++; m_st1 = n1; m_st2 = n2;
      end
    end
    @(posedge clk);
    #1;
    check("dout_vld", 32'(dout_vld), 32'(v));
    if (dout_vld === 1'b1) begin
      check("q_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout_sys", 32'(dout_sys), 32'(e[6:5]));
        check("dout_par", 32'(dout_par), 32'(e[4:3]));
        check("par_mask", 32'(par_mask), 32'(e[2:1]));
        check("blk_last", 32'(blk_last), 32'(e[0]));
        hold_sys = e[6:5];
        hold_par = e[4:3];
      end
      vld_seen++;
      if (blk_last === 1'b1) last_seen++;
    end else begin
      check("gap_mask", 32'(par_mask), 0);
      check("gap_last", 32'(blk_last), 0);
      check("gap_sys_hold", 32'(dout_sys), 32'(hold_sys));
      check("gap_par_hold", 32'(dout_par), 32'(hold_par));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, 32'(dout_vld), 0);
    check({tag, "_sys"}, 32'(dout_sys), 0);
    check({tag, "_par"}, 32'(dout_par), 0);
    check({tag, "_mask"}, 32'(par_mask), 0);
    check({tag, "_last"}, 32'(blk_last), 0);
  endtask

  // Asynchronous reset asserted away from the clock edge.
  task automatic do_reset();
    din_vld = 1'b0;
    n_rst   = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    vld_seen = 0;
    last_seen = 0;
  endtask

  initial begin
    int         n;
    logic [1:0] pb;
    n_rst = 1'b1; din_vld = 1'b0; din_sys = 2'b00; din_itl = 2'b00; pb_size = 2'b00;
    model_reset();
    vld_seen = 0; last_seen = 0;
    #2;

    // 1: reset, idle for 10 cycles
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00);
      check_zero("idle");
    end

    // 2: directed parity from the zero state
    do_reset();
    step(1'b1, 2'b11, 2'b11, 2'b00);
    check("t2_par0", 32'(dout_par), 32'h0);
    step(1'b1, 2'b00, 2'b00, 2'b00);
    check("t2_par1", 32'(dout_par), 32'h3);

    // 3: 64-symbol block back-to-back, then next block starts from zero state
    do_reset();
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00);
      check("t3_last_pos", 32'(blk_last), (k == 63) ? 1 : 0);
    end
    check("t3_vld_cnt", vld_seen, 64);
    check("t3_last_cnt", last_seen, 1);
    step(1'b1, 2'b11, 2'b11, 2'b00);
    check("t3_next_par", 32'(dout_par), 32'h0);
`ifdef TURBO_PUNCT_EN
    check("t3_next_mask", 32'(par_mask), 32'h1);
`else
    check("t3_next_mask", 32'(par_mask), 32'h3);
`endif

    // 4: 2080-symbol block with random gaps and pb_size toggled mid-block
    do_reset();
    n = 0;
    while (n < 2080) begin
      pb = (n == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pb);
      end else begin
        step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pb);
        n++;
      end
    end
    step(1'b0, 2'b00, 2'b00, 2'b00);
    check("t4_vld_cnt", vld_seen, 2080);
    check("t4_last_cnt", last_seen, 1);

    // 4b: reserved pb_size 2'b11 behaves as the largest block
    vld_seen = 0; last_seen = 0;
    for (int k = 0; k < 2080; k++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           (k == 0) ? 2'b11 : 2'b00);
    end
    check("t4b_last_cnt", last_seen, 1);
    check("t4b_last_end", 32'(blk_last), 1);

    // 5: reset at symbol 300 of a 544 block, then a fresh 544 block
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b01);
    end
    check("t5_no_last", last_seen, 0);
    do_reset();
    check_zero("t5_after_rst");
    for (int k = 0; k < 544; k++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           (k == 0) ? 2'b01 : 2'($urandom_range(0, 3)));
    end
    check("t5_vld_cnt", vld_seen, 544);
    check("t5_last_cnt", last_seen, 1);
    step(1'b0, 2'b00, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
